tpu_host_sequencer: RTL and testbench

//  Initiator for the TPU top-level control/memory interface. Accepts one command at a time (LOAD_W,

---
 rtl/tpu_seq_pkg.sv | 29 ++
 rtl/tpu_seq_skid_buf.sv | 62 ++++++
 rtl/tpu_host_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_tpu_host_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_seq_pkg.sv
// Shared types and constants for the TPU host sequencer.
// Optional done-wait watchdog is enabled by defining TPU_SEQ_TIMEOUT_EN.
package tpu_seq_pkg;

   localparam int unsigned N_DEF     = 16;
   localparam int unsigned ROW_CNT_W = $clog2(N_DEF);
   localparam int unsigned RES_W     = 16;
   localparam int unsigned TMO_W     = 11;

   typedef enum logic [1:0] {
      OP_LOAD_W  = 2'd0,
      OP_MATMUL  = 2'd1,
      OP_READOUT = 2'd2,
      OP_RSVD    = 2'd3
   } cmd_op_e;

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      WL_READ  = 4'd1,
      WL_WAIT  = 4'd2,
      WA_KICK  = 4'd3,
      WA_WAIT  = 4'd4,
      MM_KICK  = 4'd5,
      MM_WAIT  = 4'd6,
      RD_ISSUE = 4'd7,
      RD_DRAIN = 4'd8
   } state_e;

endpackage

// File: rtl/tpu_seq_skid_buf.sv
// Two-entry FIFO carrying {last, data} result rows with valid/ready on both sides.
module tpu_seq_skid_buf #(
   parameter int unsigned DW = 256
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   input  logic          in_last,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          out_last,
   output logic [1:0]    count
);

   logic [DW:0] mem_q [2];
   logic [DW:0] mem_d [2];
   logic        wr_ptr_q, wr_ptr_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        push, pop;

   assign in_ready  = (cnt_q != 2'd2);
   assign out_valid = (cnt_q != 2'd0);
   assign out_data  = mem_q[rd_ptr_q][DW-1:0];
   assign out_last  = mem_q[rd_ptr_q][DW];
   assign count     = cnt_q;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q] = {in_last, in_data};
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      cnt_d = cnt_q + 2'(push) - 2'(pop);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/tpu_host_sequencer.sv
// Host-side command sequencer for the TPU top: weight load, matmul kick and result readout.
// Define TPU_SEQ_TIMEOUT_EN to bound the done-flag waits with a watchdog that sets err.
module tpu_host_sequencer
   import tpu_seq_pkg::*;
#(
   parameter int unsigned WIDTH_HEIGHT = 16,
   parameter int unsigned ADDR_W       = 8,
   parameter int unsigned TIMEOUT      = 1024
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           cmd_valid,
   output logic                           cmd_ready,
   input  logic [1:0]                     cmd_op,
   input  logic [ADDR_W-1:0]              cmd_base,
   input  logic [ADDR_W-1:0]              cmd_out_base,
   output logic                           mem_to_fifo,
   output logic                           fifo_to_arr,
   output logic [WIDTH_HEIGHT-1:0]        weight_write,
   output logic                           active,
   output logic [WIDTH_HEIGHT-1:0]        weightMem_rd_en,
   output logic [WIDTH_HEIGHT*ADDR_W-1:0] weightMem_rd_addr,
   output logic [WIDTH_HEIGHT*ADDR_W-1:0] inputMem_rd_addr_base,
   output logic [WIDTH_HEIGHT*ADDR_W-1:0] outputMem_wr_addr_base,
   output logic [WIDTH_HEIGHT-1:0]        outputMem_rd_en,
   output logic [WIDTH_HEIGHT*ADDR_W-1:0] outputMem_rd_addr,
   input  logic                           mem_to_fifo_done,
   input  logic                           fifo_to_arr_done,
   input  logic                           output_done,
   input  logic [WIDTH_HEIGHT*RES_W-1:0]  outputMem_rd_data,
   output logic                           res_valid,
   input  logic                           res_ready,
   output logic [WIDTH_HEIGHT*RES_W-1:0]  res_data,
   output logic                           res_last,
   output logic                           busy,
   output logic                           err
);

   localparam int unsigned RW = (WIDTH_HEIGHT == N_DEF) ? ROW_CNT_W :
                                ((WIDTH_HEIGHT > 1) ? $clog2(WIDTH_HEIGHT) : 1);
   localparam int unsigned DW = WIDTH_HEIGHT * RES_W;

`ifdef TPU_SEQ_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   state_e            state_q, state_d;
   logic [RW-1:0]     row_q, row_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W-1:0] in_base_q, in_base_d;
   logic [ADDR_W-1:0] out_base_q, out_base_d;
   logic              m2f_q, m2f_d;
   logic              pend_q, pend_d;
   logic              pend_last_q, pend_last_d;
   logic              err_q, err_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;

   logic              rd_issue, row_last, in_wait, tmo_hit;
   logic [ADDR_W-1:0] row_addr;
   logic              buf_in_ready;
   logic [1:0]        buf_cnt;

   assign row_last = (row_q == RW'(WIDTH_HEIGHT - 1));
   assign row_addr = base_q + ADDR_W'(row_q);
   assign in_wait  = (state_q == WL_WAIT) || (state_q == WA_WAIT) || (state_q == MM_WAIT);
   assign tmo_hit  = TMO_EN && (tmo_q == TMO_W'(TIMEOUT - 1));

   // Issue a readout row only if the buffer can absorb it together with any read in flight.
   assign rd_issue = (state_q == RD_ISSUE) && buf_in_ready && !(pend_q && (buf_cnt == 2'd1));

   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      base_d      = base_q;
      in_base_d   = in_base_q;
      out_base_d  = out_base_q;
      err_d       = err_q;
      m2f_d       = 1'b0;
      pend_d      = rd_issue;
      pend_last_d = rd_issue && row_last;
      tmo_d       = (TMO_EN && in_wait) ? tmo_q + TMO_W'(1) : '0;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               case (cmd_op_e'(cmd_op))
                  OP_LOAD_W: begin
                     base_d  = cmd_base;
                     row_d   = '0;
                     state_d = WL_READ;
                  end
                  OP_MATMUL: begin
                     in_base_d  = cmd_base;
                     out_base_d = cmd_out_base;
                     state_d    = MM_KICK;
                  end
                  OP_READOUT: begin
                     base_d  = cmd_base;
                     row_d   = '0;
                     state_d = RD_ISSUE;
                  end
                  default: err_d = 1'b1;
               endcase
            end
         end
         WL_READ: begin
            m2f_d = (row_q == '0);
            row_d = row_q + RW'(1);
            if (row_last) state_d = WL_WAIT;
         end
         WL_WAIT: begin
            if (mem_to_fifo_done) state_d = WA_KICK;
            else if (tmo_hit) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         WA_KICK: state_d = WA_WAIT;
         WA_WAIT: begin
            if (fifo_to_arr_done) state_d = IDLE;
            else if (tmo_hit) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         MM_KICK: state_d = MM_WAIT;
         MM_WAIT: begin
            if (output_done) state_d = IDLE;
            else if (tmo_hit) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         RD_ISSUE: begin
            if (rd_issue) begin
               row_d = row_q + RW'(1);
               if (row_last) state_d = RD_DRAIN;
            end
         end
         RD_DRAIN: begin
            if (!pend_q && (buf_cnt == 2'd0)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         row_q       <= '0;
         base_q      <= '0;
         in_base_q   <= '0;
         out_base_q  <= '0;
         m2f_q       <= 1'b0;
         pend_q      <= 1'b0;
         pend_last_q <= 1'b0;
         err_q       <= 1'b0;
         tmo_q       <= '0;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         base_q      <= base_d;
         in_base_q   <= in_base_d;
         out_base_q  <= out_base_d;
         m2f_q       <= m2f_d;
         pend_q      <= pend_d;
         pend_last_q <= pend_last_d;
         err_q       <= err_d;
         tmo_q       <= tmo_d;
      end
   end

   tpu_seq_skid_buf #(.DW(DW)) u_skid (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (pend_q),
      .in_ready  (buf_in_ready),
      .in_data   (outputMem_rd_data),
      .in_last   (pend_last_q),
      .out_valid (res_valid),
      .out_ready (res_ready),
      .out_data  (res_data),
      .out_last  (res_last),
      .count     (buf_cnt)
   );

   assign cmd_ready              = (state_q == IDLE);
   assign busy                   = (state_q != IDLE);
   assign err                    = err_q;
   assign mem_to_fifo            = m2f_q;
   assign fifo_to_arr            = (state_q == WA_KICK);
   assign active                 = (state_q == MM_KICK);
   assign weight_write           = ((state_q == WA_KICK) || (state_q == WA_WAIT)) ? '1 : '0;
   assign weightMem_rd_en        = (state_q == WL_READ) ? '1 : '0;
   assign weightMem_rd_addr      = (state_q == WL_READ) ? {WIDTH_HEIGHT{row_addr}} : '0;
   assign outputMem_rd_en        = rd_issue ? '1 : '0;
   assign outputMem_rd_addr      = rd_issue ? {WIDTH_HEIGHT{row_addr}} : '0;
   assign inputMem_rd_addr_base  = {WIDTH_HEIGHT{in_base_q}};
   assign outputMem_wr_addr_base = {WIDTH_HEIGHT{out_base_q}};

endmodule

// File: tb/tb_tpu_host_sequencer.sv
// Directed bench for tpu_host_sequencer: load, matmul, readout with backpressure, error and reset.
module tb_tpu_host_sequencer;

   localparam int unsigned N  = 16;
   localparam int unsigned AW = 8;

   logic            clk = 1'b0;
   logic            reset;
   logic            cmd_valid, cmd_ready;
   logic [1:0]      cmd_op;
   logic [AW-1:0]   cmd_base, cmd_out_base;
   logic            mem_to_fifo, fifo_to_arr, active;
   logic [N-1:0]    weight_write, weightMem_rd_en, outputMem_rd_en;
   logic [N*AW-1:0] weightMem_rd_addr, inputMem_rd_addr_base, outputMem_wr_addr_base, outputMem_rd_addr;
   logic            mem_to_fifo_done, fifo_to_arr_done, output_done;
   logic [N*16-1:0] outputMem_rd_data, res_data;
   logic            res_valid, res_ready, res_last, busy, err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   tpu_host_sequencer dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_base(cmd_base), .cmd_out_base(cmd_out_base),
      .mem_to_fifo(mem_to_fifo), .fifo_to_arr(fifo_to_arr), .weight_write(weight_write),
      .active(active), .weightMem_rd_en(weightMem_rd_en), .weightMem_rd_addr(weightMem_rd_addr),
      .inputMem_rd_addr_base(inputMem_rd_addr_base), .outputMem_wr_addr_base(outputMem_wr_addr_base),
      .outputMem_rd_en(outputMem_rd_en), .outputMem_rd_addr(outputMem_rd_addr),
      .mem_to_fifo_done(mem_to_fifo_done), .fifo_to_arr_done(fifo_to_arr_done),
      .output_done(output_done), .outputMem_rd_data(outputMem_rd_data),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
      .busy(busy), .err(err)
   );

   function automatic logic [N*16-1:0] row_data(input logic [AW-1:0] a);
      logic [N*16-1:0] d;
      for (int l = 0; l < N; l++) d[l*16 +: 16] = {a, 8'(l) ^ 8'h5A};
      return d;
   endfunction

   function automatic logic [N*AW-1:0] rep(input logic [AW-1:0] a);
      return {N{a}};
   endfunction

   // Output memory model: one-cycle read latency, zeros when not read.
   always @(posedge clk)
      outputMem_rd_data <= (outputMem_rd_en == 16'hFFFF) ? row_data(outputMem_rd_addr[AW-1:0]) : '0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] op, input logic [AW-1:0] b, input logic [AW-1:0] ob);
      cmd_valid    = 1'b1;
      cmd_op       = op;
      cmd_base     = b;
      cmd_out_base = ob;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic readout(input logic [AW-1:0] base, input bit throttle);
      int            got, iss;
      logic          pv, pl;
      logic [255:0]  pd;
      got = 0; iss = 0; pv = 1'b0; pl = 1'b0; pd = '0;
      res_ready = !throttle;
      send(2'd2, base, 8'h00);
      for (int cyc = 0; cyc < 400 && !(got == N && !busy); cyc++) begin
         if (throttle) res_ready = (cyc % 3 == 0) && !(cyc >= 6 && cyc < 26);
         if (outputMem_rd_en != '0) begin
            chk("rd_addr", 256'(outputMem_rd_addr), 256'(rep(8'(base + iss))));
            iss++;
         end
         if (pv) begin
            chk("stall_valid", 256'(res_valid), 256'(1));
            chk("stall_data", res_data, pd);
            chk("stall_last", 256'(res_last), 256'(pl));
         end
         if (res_valid && res_ready) begin
            chk("res_data", res_data, row_data(8'(base + got)));
            chk("res_last", 256'(res_last), 256'(got == N - 1));
            got++;
         end
         pv = res_valid && !res_ready;
         pd = res_data;
         pl = res_last;
         step();
      end
      chk("rd_rows", 256'(got), 256'(N));
      chk("rd_issues", 256'(iss), 256'(N));
      chk("rd_busy", 256'(busy), 256'(0));
      res_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_base = '0; cmd_out_base = '0;
      mem_to_fifo_done = 1'b0; fifo_to_arr_done = 1'b0; output_done = 1'b0; res_ready = 1'b0;
      step(); step();
      reset = 1'b0;
      step();
      chk("rst_cmd_ready", 256'(cmd_ready), 256'(1));
      chk("rst_busy", 256'(busy), 256'(0));
      chk("rst_err", 256'(err), 256'(0));
      chk("rst_res_valid", 256'(res_valid), 256'(0));
      chk("rst_in_base", 256'(inputMem_rd_addr_base), 256'(0));

      // LOAD_W
      send(2'd0, 8'h10, 8'h00);
      for (int k = 0; k < N; k++) begin
         chk("wl_rd_en", 256'(weightMem_rd_en), 256'(16'hFFFF));
         chk("wl_rd_addr", 256'(weightMem_rd_addr), 256'(rep(8'(8'h10 + k))));
         chk("wl_m2f", 256'(mem_to_fifo), 256'(k == 1));
         chk("wl_ready", 256'(cmd_ready), 256'(0));
         step();
      end
      chk("wlw_rd_en", 256'(weightMem_rd_en), 256'(0));
      chk("wlw_busy", 256'(busy), 256'(1));
      step(); step();
      chk("wlw_f2a", 256'(fifo_to_arr), 256'(0));
      mem_to_fifo_done = 1'b1;
      step();
      mem_to_fifo_done = 1'b0;
      chk("wa_f2a", 256'(fifo_to_arr), 256'(1));
      chk("wa_ww", 256'(weight_write), 256'(16'hFFFF));
      step();
      chk("waw_f2a", 256'(fifo_to_arr), 256'(0));
      chk("waw_ww", 256'(weight_write), 256'(16'hFFFF));
      step(); step();
      fifo_to_arr_done = 1'b1;
      chk("waw_ww_done", 256'(weight_write), 256'(16'hFFFF));
      step();
      fifo_to_arr_done = 1'b0;
      chk("wl_end_ww", 256'(weight_write), 256'(0));
      chk("wl_end_busy", 256'(busy), 256'(0));

      // MATMUL
      send(2'd1, 8'h20, 8'h40);
      chk("mm_active", 256'(active), 256'(1));
      chk("mm_in_base", 256'(inputMem_rd_addr_base), 256'(rep(8'h20)));
      chk("mm_out_base", 256'(outputMem_wr_addr_base), 256'(rep(8'h40)));
      step();
      chk("mm_active_off", 256'(active), 256'(0));
      for (int k = 0; k < 5; k++) begin
         chk("mm_busy", 256'(busy), 256'(1));
         step();
      end
      output_done = 1'b1;
      step();
      output_done = 1'b0;
      chk("mm_end_busy", 256'(busy), 256'(0));
      chk("mm_hold_base", 256'(inputMem_rd_addr_base), 256'(rep(8'h20)));

      // MATMUL with done already high at wait entry
      output_done = 1'b1;
      send(2'd1, 8'h33, 8'h55);
      chk("mm2_busy_kick", 256'(busy), 256'(1));
      step();
      chk("mm2_busy_wait", 256'(busy), 256'(1));
      step();
      output_done = 1'b0;
      chk("mm2_end_busy", 256'(busy), 256'(0));
      chk("mm2_out_base", 256'(outputMem_wr_addr_base), 256'(rep(8'h55)));

      // READOUT
      readout(8'hF8, 1'b0);
      readout(8'h30, 1'b1);

`ifdef TPU_SEQ_TIMEOUT_EN
      send(2'd1, 8'h01, 8'h02);
      step();
      repeat (1023) step();
      chk("tmo_busy", 256'(busy), 256'(1));
      step();
      chk("tmo_idle", 256'(busy), 256'(0));
      chk("tmo_err", 256'(err), 256'(1));
`endif

      // reserved op
      send(2'd3, 8'h00, 8'h00);
      chk("rsvd_err", 256'(err), 256'(1));
      chk("rsvd_ready", 256'(cmd_ready), 256'(1));
      chk("rsvd_busy", 256'(busy), 256'(0));

      // reset in the middle of LOAD_W
      send(2'd0, 8'h80, 8'h00);
      step();
      chk("mid_m2f", 256'(mem_to_fifo), 256'(1));
      reset = 1'b1;
      #1;
      chk("arst_m2f", 256'(mem_to_fifo), 256'(0));
      chk("arst_rd_en", 256'(weightMem_rd_en), 256'(0));
      chk("arst_rd_addr", 256'(weightMem_rd_addr), 256'(0));
      chk("arst_busy", 256'(busy), 256'(0));
      chk("arst_err", 256'(err), 256'(0));
      chk("arst_ww", 256'(weight_write), 256'(0));
      chk("arst_in_base", 256'(inputMem_rd_addr_base), 256'(0));
      chk("arst_out_base", 256'(outputMem_wr_addr_base), 256'(0));
      chk("arst_res_valid", 256'(res_valid), 256'(0));
      step();
      reset = 1'b0;
      step();
      chk("post_rst_ready", 256'(cmd_ready), 256'(1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
